// File: rtl/md_vel_pkg.sv
// Shared constants and FSM state type for the velocity ping-pong cell buffer.
package md_vel_pkg;

    // One velocity component is a single-precision float.
    localparam int unsigned FloatWidth     = 32;
    // A velocity record is {vz, vy, vx}.
    localparam int unsigned DefDataWidth   = 3 * FloatWidth;
    localparam int unsigned DefParticleNum = 220;
    localparam int unsigned DefAddrWidth   = 8;

    typedef enum logic [1:0] {
        StActive = 2'd0,
        StDrain  = 2'd1,
        StSwap   = 2'd2
    } vel_state_e;

    // What the registered read response carries.
    localparam logic [1:0] RdKindCount = 2'd0;
    localparam logic [1:0] RdKindBank  = 2'd1;
    localparam logic [1:0] RdKindZero  = 2'd2;

endpackage

// File: rtl/velocity_bank.sv
// Single-port velocity RAM with a registered read output (1-cycle read latency).
// Contents are never reset; the owning cell's counts decide which entries are live.
module velocity_bank
    import md_vel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // One access per cycle: a write, or a read into the output register.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/velocity_cell_pingpong.sv
// Ping-pong velocity buffer for one cell: the read bank serves force/motion-update
// reads while motion-update results fill the write bank; banks swap at the iteration
// boundary via an ACTIVE -> DRAIN -> SWAP handshake.
// Optional feature: define VEL_PINGPONG_OVF_CHK_EN to enable the sticky overflow_err flag.
module velocity_cell_pingpong
    import md_vel_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DefDataWidth,
    parameter int unsigned PARTICLE_NUM = DefParticleNum,
    parameter int unsigned ADDR_WIDTH   = DefAddrWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  swap_req,
    output logic                  swap_done,
    output logic [ADDR_WIDTH-1:0] rd_count,
    output logic [ADDR_WIDTH-1:0] wr_count,
    output logic                  overflow_err
);

    localparam logic [ADDR_WIDTH-1:0] PartMax = ADDR_WIDTH'(PARTICLE_NUM);

    vel_state_e            state_q, state_d;
    logic                  bank_sel_q, bank_sel_d;  // index of the read bank
    logic [ADDR_WIDTH-1:0] rd_count_q, rd_count_d;
    logic [ADDR_WIDTH-1:0] wr_count_q, wr_count_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [1:0]            rd_kind_q, rd_kind_d;
    logic                  swap_done_q, swap_done_d;

    logic                  rd_take, rd_fire, wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  bank_en [2];
    logic                  bank_we [2];
    logic [ADDR_WIDTH-1:0] bank_addr [2];
    logic [DATA_WIDTH-1:0] bank_rdata [2];

    // Address 0 holds the count, so records live at 1..count.
    assign rd_take  = rd_en && (state_q != StSwap);
    assign rd_fire  = rd_take && (rd_addr != '0) && (rd_addr <= rd_count_q);
    assign wr_ready = (state_q == StActive) && (wr_count_q != PartMax);
    assign wr_fire  = wr_valid && wr_ready;
    assign wr_addr  = wr_count_q + 1'b1;

    // Steer the read port to the read bank and the write port to the other one.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            if (bank_sel_q == 1'(i)) begin
                bank_en[i]   = rd_fire;
                bank_we[i]   = 1'b0;
                bank_addr[i] = rd_addr;
            end else begin
                bank_en[i]   = wr_fire;
                bank_we[i]   = wr_fire;
                bank_addr[i] = wr_addr;
            end
        end
    end

    velocity_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank0 (
        .clk   (clk),
        .en    (bank_en[0]),
        .we    (bank_we[0]),
        .addr  (bank_addr[0]),
        .wdata (wr_data),
        .rdata (bank_rdata[0])
    );

    velocity_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank1 (
        .clk   (clk),
        .en    (bank_en[1]),
        .we    (bank_we[1]),
        .addr  (bank_addr[1]),
        .wdata (wr_data),
        .rdata (bank_rdata[1])
    );

    // Swap FSM, write counter and read-response bookkeeping.
    always_comb begin
        state_d     = state_q;
        bank_sel_d  = bank_sel_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        swap_done_d = (state_q == StSwap);
        rd_valid_d  = rd_take;
        rd_kind_d   = rd_kind_q;

        if (rd_take) begin
            if (rd_addr == '0) begin
                rd_kind_d = RdKindCount;
            end else if (rd_addr > rd_count_q) begin
                rd_kind_d = RdKindZero;
            end else begin
                rd_kind_d = RdKindBank;
            end
        end

        if (wr_fire) begin
            wr_count_d = wr_count_q + 1'b1;
        end

        unique case (state_q)
            StActive: begin
                if (swap_req) begin
                    state_d = StDrain;
                end
            end
            // A read issued here still targets the old bank, so hold until reads stop.
            StDrain: begin
                if (!rd_en) begin
                    state_d = StSwap;
                end
            end
            StSwap: begin
                state_d    = StActive;
                bank_sel_d = ~bank_sel_q;
                rd_count_d = wr_count_q;
                wr_count_d = '0;
            end
            default: state_d = StActive;
        endcase
    end

    // State registers; RAM contents are deliberately left untouched by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StActive;
            bank_sel_q  <= 1'b0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            rd_valid_q  <= 1'b0;
            rd_kind_q   <= RdKindZero;
            swap_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_sel_q  <= bank_sel_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            rd_valid_q  <= rd_valid_d;
            rd_kind_q   <= rd_kind_d;
            swap_done_q <= swap_done_d;
        end
    end

    // Response mux. bank_sel_q and rd_count_q only change at the end of SWAP, and
    // no read is issued in SWAP, so they still match the values seen at issue time.
    always_comb begin
        rd_data = '0;
        if (rd_valid_q) begin
            unique case (rd_kind_q)
                RdKindCount: rd_data = {{(DATA_WIDTH - ADDR_WIDTH){1'b0}}, rd_count_q};
                RdKindBank:  rd_data = bank_rdata[bank_sel_q];
                default:     rd_data = '0;
            endcase
        end
    end

    assign rd_valid  = rd_valid_q;
    assign swap_done = swap_done_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;

`ifdef VEL_PINGPONG_OVF_CHK_EN
    logic ovf_q, ovf_d;

    // Sticky: any offer against a full write bank is recorded until reset.
    always_comb begin
        ovf_d = ovf_q | (wr_valid && (wr_count_q == PartMax));
    end

    // Overflow flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow_err = ovf_q;
`else
    assign overflow_err = 1'b0;
`endif

endmodule
